// File: rtl/seq_divider_rv32_pkg.sv
// Shared definitions for the RV32M sequential divider: op codes, FSM encodings
// and the per-operation context captured when a request is accepted.
package seq_divider_rv32_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_FIX    = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  typedef struct packed {
    logic [1:0] op;
    logic       negA;
    logic       negB;
  } opCtx_t;

  function automatic logic isSignedOp(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/seq_divider_rv32_if.sv
// Request/response bundle between the control unit (master) and the divider (slave).
interface seq_divider_rv32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/seq_divider_rv32_div_sub_step.sv
// One restoring-division step: trial subtract Dabs from the shifted remainder
// as Rs + ~{0,Dabs} + 1 and keep the difference only when it did not borrow.
module seq_divider_rv32_div_sub_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rs_i,
  input  logic [WIDTH-1:0] dabs_i,
  output logic [WIDTH:0]   r_o,
  output logic             qbit_o
);

  logic [WIDTH:0]   dabsInv;
  logic [WIDTH+1:0] sum;

  assign dabsInv = ~{1'b0, dabs_i};
  // The carry out of the extended sum is set exactly when Rs >= Dabs.
  assign sum     = {1'b0, rs_i} + {1'b0, dabsInv} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign qbit_o  = sum[WIDTH+1];
  assign r_o     = qbit_o ? sum[WIDTH:0] : rs_i;

endmodule

// File: rtl/seq_divider_rv32.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit
// per cycle, with divide-by-zero and signed overflow resolved at acceptance.
module seq_divider_rv32
  import seq_divider_rv32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  seq_divider_rv32_if.slave  div_if
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  opCtx_t           ctx_q, ctx_d;
  logic [WIDTH-1:0] dabs_q, dabs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]   remShifted;
  logic [WIDTH:0]   remStep;
  logic             quoBit;

  logic             reqSigned;
  logic             reqNegA;
  logic             reqNegB;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic             divByZero;
  logic             overflow;
  logic [WIDTH-1:0] fixQuo;
  logic [WIDTH-1:0] fixRem;

  assign remShifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

  seq_divider_rv32_div_sub_step #(.WIDTH(WIDTH)) u_sub_step (
    .rs_i   (remShifted),
    .dabs_i (dabs_q),
    .r_o    (remStep),
    .qbit_o (quoBit)
  );

  // Operand magnitudes and special cases are evaluated on the raw request.
  assign reqSigned = isSignedOp(div_if.op);
  assign reqNegA   = reqSigned & div_if.a[WIDTH-1];
  assign reqNegB   = reqSigned & div_if.b[WIDTH-1];
  assign absA      = reqNegA ? (~div_if.a + WIDTH'(1)) : div_if.a;
  assign absB      = reqNegB ? (~div_if.b + WIDTH'(1)) : div_if.b;
  assign divByZero = (div_if.b == '0);
  assign overflow  = reqSigned && (div_if.a == {1'b1, {(WIDTH-1){1'b0}}}) && (div_if.b == '1);

  // Unsigned ops never set negA/negB, so they pass through unchanged.
  assign fixQuo = (isSignedOp(ctx_q.op) && (ctx_q.negA ^ ctx_q.negB)) ? (~quo_q + WIDTH'(1)) : quo_q;
  assign fixRem = ctx_q.negA ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    ctx_d    = ctx_q;
    dabs_d   = dabs_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (state_q == ST_FINISH) begin
          state_d = ST_IDLE;
        end
        if (div_if.start) begin
          ctx_d.op   = div_if.op;
          ctx_d.negA = reqNegA;
          ctx_d.negB = reqNegB;
          dabs_d     = absB;
          quo_d      = absA;
          rem_d      = '0;
          cnt_d      = CNT_W'(WIDTH - 1);
          if (divByZero) begin
            result_d = div_if.op[1] ? div_if.a : '1;
            state_d  = ST_FINISH;
          end else if (overflow) begin
            result_d = div_if.op[1] ? '0 : div_if.a;
            state_d  = ST_FINISH;
          end else begin
            state_d  = ST_DIVIDE;
          end
        end
      end

      ST_DIVIDE: begin
        rem_d = remStep;
        quo_d = {quo_q[WIDTH-2:0], quoBit};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        result_d = ctx_q.op[1] ? fixRem : fixQuo;
        state_d  = ST_FINISH;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      ctx_q    <= '0;
      dabs_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ctx_q    <= ctx_d;
      dabs_q   <= dabs_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign div_if.busy   = (state_q == ST_DIVIDE) || (state_q == ST_FIX);
  assign div_if.done   = (state_q == ST_FINISH);
  assign div_if.result = result_q;

endmodule

// File: tb/tb_seq_divider_rv32.sv
// Directed and randomised checks of seq_divider_rv32 against an RV32M reference
// model, with expected results queued at issue and popped at DONE.
module tb_seq_divider_rv32;
  import seq_divider_rv32_pkg::*;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq_divider_rv32_if #(.WIDTH(WIDTH)) divIf ();

  seq_divider_rv32 #(.WIDTH(WIDTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .div_if (divIf)
  );

  int assertCount = 0;
  int failCount = 0;
  int cycleCount = 0;
  int acceptCycle = 0;
  int busyCount = 0;
  logic [WIDTH-1:0] expQ[$];

  always @(posedge clk) cycleCount++;
  always @(negedge clk) if (divIf.busy) busyCount++;

  function automatic logic isSpecial(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (b == '0) || (isSignedOp(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [WIDTH-1:0] refModel(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIVU: return (b == '0) ? '1 : a / b;
      OP_REMU: return (b == '0) ? a : a % b;
      OP_DIV:  return (b == '0) ? '1 : (ovf ? a : $unsigned($signed(a) / $signed(b)));
      default: return (b == '0) ? a : (ovf ? '0 : $unsigned($signed(a) % $signed(b)));
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives a request and returns just after the accepting edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    divIf.op = op;
    divIf.a = a;
    divIf.b = b;
    divIf.start = 1'b1;
    expQ.push_back(refModel(op, a, b));
    @(posedge clk);
    #1;
    acceptCycle = cycleCount;
    busyCount = 0;
    divIf.start = 1'b0;
  endtask

  // Waits (bounded) for DONE, then checks latency, BUSY duration and result.
  task automatic waitDone(input string tag, input int expLat, input int expBusy);
    bit seen;
    int lat;
    logic [WIDTH-1:0] exp;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (divIf.done === 1'b1) seen = 1'b1;
    end
    checkOutput({tag, " done seen"}, WIDTH'(seen), WIDTH'(1));
    exp = (expQ.size() > 0) ? expQ.pop_front() : 'x;
    if (seen) begin
      lat = cycleCount - acceptCycle + 1;
      checkOutput({tag, " latency"}, WIDTH'(lat), WIDTH'(expLat));
      checkOutput({tag, " busy cycles"}, WIDTH'(busyCount), WIDTH'(expBusy));
      checkOutput({tag, " result"}, divIf.result, exp);
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    applyStimulus(op, a, b);
    if (isSpecial(op, a, b)) waitDone(tag, 1, 0);
    else waitDone(tag, WIDTH + 2, WIDTH + 1);
  endtask

  task automatic checkIdleAfter(input string tag, input logic [WIDTH-1:0] held);
    @(negedge clk);
    checkOutput({tag, " done pulse ends"}, WIDTH'(divIf.done), WIDTH'(0));
    checkOutput({tag, " result held"}, divIf.result, held);
  endtask

  initial begin
    logic [1:0] rop;
    logic [WIDTH-1:0] ra, rb;

    divIf.start = 1'b0;
    divIf.op = OP_DIV;
    divIf.a = '0;
    divIf.b = '0;

    #12;
    checkOutput("reset busy", WIDTH'(divIf.busy), WIDTH'(0));
    checkOutput("reset done", WIDTH'(divIf.done), WIDTH'(0));
    checkOutput("reset result", divIf.result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    runOp("divu 100/7", OP_DIVU, 32'd100, 32'd7);
    checkIdleAfter("divu 100/7", 32'd14);
    runOp("remu 100/7", OP_REMU, 32'd100, 32'd7);
    checkIdleAfter("remu 100/7", 32'd2);
    runOp("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    runOp("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk);

    runOp("divu by zero", OP_DIVU, 32'h0000_1234, 32'd0);
    checkIdleAfter("divu by zero", 32'hFFFF_FFFF);
    runOp("rem by zero", OP_REM, 32'hFFFF_FFFB, 32'd0);
    runOp("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("rem overflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    @(negedge clk);

    // A second request in the middle of a division must be dropped.
    applyStimulus(OP_DIVU, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    divIf.op = OP_REMU;
    divIf.a = 32'd5;
    divIf.b = 32'd1;
    divIf.start = 1'b1;
    @(posedge clk);
    #1;
    divIf.start = 1'b0;
    waitDone("ignored start", WIDTH + 2, WIDTH + 1);
    checkIdleAfter("ignored start", 32'd142);

    // Back-to-back: the next request is presented during the FINISH cycle.
    applyStimulus(OP_DIVU, 32'd12345, 32'd100);
    waitDone("b2b first", WIDTH + 2, WIDTH + 1);
    runOp("b2b second", OP_REM, 32'h8000_0001, 32'd3);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      runOp($sformatf("random %0d op%0d", i, rop), rop, ra, rb);
    end
    @(negedge clk);

    // Asynchronous reset in the middle of a DIVU discards the operation.
    applyStimulus(OP_DIVU, 32'hFFFF_0000, 32'd3);
    void'(expQ.pop_back());
    repeat (14) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", WIDTH'(divIf.busy), WIDTH'(0));
    checkOutput("async reset done", WIDTH'(divIf.done), WIDTH'(0));
    checkOutput("async reset result", divIf.result, '0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    runOp("divu 9/3 after reset", OP_DIVU, 32'd9, 32'd3);

    checkOutput("scoreboard drained", WIDTH'(expQ.size()), WIDTH'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/seq_divider_rv32.md
Name: seq_divider_rv32

Overview:
- Multi-cycle restoring divider for the ALU that implements RV32M DIV, DIVU, REM and REMU.
- It is the inverse-direction companion of the carry look-ahead adder. It produces one quotient bit per cycle by trial subtraction, computed as A + ~B + 1.
- It sits beside the combinational ALU. The control unit starts it with a START/DONE handshake and holds the pipeline while BUSY is high.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- CLK  input  1  rising-edge clock; the only clock.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  request pulse; sampled on the rising edge of CLK.
- OP  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- A  input  WIDTH  dividend; sampled only on an accepted START.
- B  input  WIDTH  divisor; sampled only on an accepted START.
- BUSY  output  1  high while a division is in progress.
- DONE  output  1  one-cycle pulse; RESULT is valid in that cycle.
- RESULT  output  WIDTH  quotient or remainder, as selected by OP.

Behaviour:
- Reset
  - Asynchronous, active-low, allowed at any time, including mid-division.
  - Forces state IDLE, BUSY=0, DONE=0, RESULT=0, and clears all internal registers. The in-flight operation is discarded.
- States: IDLE, DIVIDE, FIX, FINISH.
- Accepting START
  - START is accepted only in IDLE or FINISH, which allows back-to-back operations. START in DIVIDE or FIX is ignored.
  - On acceptance, register OP and the signs of A and B. Load Dabs=|B| and Q=|A| (magnitudes only for signed ops), R=0 (WIDTH+1 bits), cnt=WIDTH-1.
- Special cases, detected at acceptance
  - B==0: next state FINISH. Quotient = all ones; remainder = A, unmodified.
  - Signed overflow (OP=DIV or REM, A=100..0, B=all ones): next state FINISH. Quotient = A; remainder = 0.
- DIVIDE state, one step per cycle
  - Shift: Rs = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - Subtract: D = Rs - {0,Dabs}.
  - If D is non-negative: R=D and Q={Q[WIDTH-2:0],1}. Otherwise R=Rs and Q={Q[WIDTH-2:0],0}.
  - cnt decrements each cycle. When cnt==0, the step executes and the next state is FIX. The state lasts exactly WIDTH cycles.
- FIX state (1 cycle): sign correction
  - DIV: quotient negated if sign(A)!=sign(B).
  - REM: remainder negated if sign(A)=1.
  - Unsigned ops are passed through.
  - RESULT is loaded with the quotient (OP[1]=0) or the remainder (OP[1]=1). Next state FINISH.
- FINISH state (1 cycle)
  - DONE=1. Next state is IDLE, or the accept path if START=1.
  - For special cases, RESULT is loaded on the acceptance edge, so FINISH immediately follows it.
- Latency
  - Normal: DONE is high in the (WIDTH+2)th cycle after the accepting edge (34 cycles for WIDTH=32).
  - Special case: DONE is high in the cycle immediately after the accepting edge.
- Outputs
  - BUSY=1 exactly in DIVIDE and FIX.
  - DONE=1 exactly in FINISH.
  - RESULT holds its value until the next FIX or special-case load, so it is stable in IDLE after completion.
- Width rules
  - Internal remainder is WIDTH+1 bits; quotient is WIDTH bits.
  - Negation is two's complement, modulo 2^WIDTH.
  - No exceptions are raised; results follow the RV32M specification.

Decomposition:
- Shared header div_defs.vh holds:
  - OP codes (OP_DIV=2'b00, OP_DIVU=2'b01, OP_REM=2'b10, OP_REMU=2'b11).
  - State encodings (IDLE=2'd0, DIVIDE=2'd1, FIX=2'd2, FINISH=2'd3).
- One combinational sub-module, div_sub_step:
  - Takes Rs and Dabs and returns the next R and the quotient bit.
  - Implements the subtraction as Rs + ~{0,Dabs} with carry-in 1.
- FSM, counter and sign logic stay in seq_divider_rv32.

Test Plan:
- DIVU: A=100, B=7 -> DONE at cycle 34 after START, RESULT=14. Same operands with REMU -> RESULT=2. BUSY high for exactly 33 cycles.
- DIV: A=-7 (0xFFFFFFF9), B=2 -> RESULT=0xFFFFFFFD (-3). REM with the same operands -> RESULT=0xFFFFFFFF (-1).
- Divide by zero:
  - DIVU A=0x1234, B=0 -> DONE the cycle after START, RESULT=0xFFFFFFFF, BUSY never high.
  - REM A=-5, B=0 -> RESULT=0xFFFFFFFB.
- Overflow: DIV A=0x80000000, B=0xFFFFFFFF -> RESULT=0x80000000 after 1 cycle. REM with the same operands -> RESULT=0.
- Handshake:
  - START pulsed with new operands at cycle 10 of a division -> ignored; result unchanged.
  - START held in the FINISH cycle -> second operation accepted; its DONE follows 34 cycles later.
- Reset: RST_N low at cycle 15 of a DIVU, asynchronous to CLK -> BUSY, DONE and RESULT become 0 immediately. After release, a fresh DIVU 9/3 -> RESULT=3.
